// File: rtl/ifetch.sv
// ifetch: MIPS IF stage -- PC, req/ack instruction fetch, skid buffer, IF/ID register, branch squash.
// Define IFETCH_PERF_EN to build the FetchCnt/BubbleCnt performance counters.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BCond,
  input  logic [31:0] NewPCVal,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PCValP4,
  output logic        InstValid,
  output logic [31:0] FetchCnt,
  output logic [31:0] BubbleCnt
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, tgt_q, tgt_d, skid_q, skid_d;
  logic [31:0] inst_q, inst_d, p4_q, p4_d, word, br_pc, pc_p4;
  logic vld_q, vld_d, ld_v, ld_b, br;
  assign br = BCond & ~Stall;
  assign br_pc = NewPCVal & ~32'h3;
  assign pc_p4 = pc_q + 32'd4;
  assign IMemReq = state_q == FETCH || state_q == DROP;
  assign IMemAddr = pc_q;
  assign Instruction = inst_q;
  assign PCValP4 = p4_q;
  assign InstValid = vld_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    skid_d = skid_q;
    ld_v = 1'b0;
    ld_b = 1'b0;
    word = IMemData;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH:
        if (br) begin
          ld_b = 1'b1;
          if (IMemAck) pc_d = br_pc;
          else begin
            tgt_d = br_pc;
            state_d = DROP;
          end
        end else if (IMemAck) begin
          if (Stall) begin
            skid_d = IMemData;
            state_d = WAIT;
          end else begin
            ld_v = 1'b1;
            pc_d = pc_p4;
          end
        end else ld_b = ~Stall;
      WAIT:
        if (!Stall) begin
          state_d = FETCH;
          word = skid_q;
          ld_v = ~BCond;
          ld_b = BCond;
          pc_d = BCond ? br_pc : pc_p4;
        end
      DROP: begin
        // the outstanding wrong-path ack is swallowed; the latest honoured target wins
        ld_b = ~Stall;
        tgt_d = br ? br_pc : tgt_q;
        if (IMemAck) begin
          pc_d = tgt_d;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    inst_d = ld_v ? word : ld_b ? 32'h0 : inst_q;
    p4_d = ld_v ? pc_p4 : ld_b ? 32'h0 : p4_q;
    vld_d = ld_v ? 1'b1 : ld_b ? 1'b0 : vld_q;
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      tgt_q <= '0;
      skid_q <= '0;
      inst_q <= '0;
      p4_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      skid_q <= skid_d;
      inst_q <= inst_d;
      p4_q <= p4_d;
      vld_q <= vld_d;
    end
`ifdef IFETCH_PERF_EN
  logic [31:0] fcnt_q, fcnt_d, bcnt_q, bcnt_d;
  assign fcnt_d = fcnt_q + {31'd0, ld_v};
  assign bcnt_d = bcnt_q + {31'd0, ld_b};
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      fcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      bcnt_q <= bcnt_d;
    end
  assign FetchCnt = fcnt_q;
  assign BubbleCnt = bcnt_q;
`else
  assign FetchCnt = '0;
  assign BubbleCnt = '0;
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table, wrap/reset sequences, then random stall/branch/latency run
// checked against an instruction-stream model.
module tb_ifetch;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] KEY = 32'hC3C3_5A5A;
  logic Clk = 0, Rst = 0, Stall = 0, BCond = 0, IMemAck = 0;
  logic [31:0] NewPCVal = 0, IMemData = 0;
  logic IMemReq, InstValid;
  logic [31:0] IMemAddr, Instruction, PCValP4, FetchCnt, BubbleCnt;
  int tests = 0, fails = 0;

  always #5 Clk = ~Clk;

  ifetch #(.RESET_PC(RPC)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .BCond(BCond), .NewPCVal(NewPCVal),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .Instruction(Instruction), .PCValP4(PCValP4), .InstValid(InstValid),
    .FetchCnt(FetchCnt), .BubbleCnt(BubbleCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] inst, input logic [31:0] p4, input logic vld);
    chk({tag, ".req"}, {31'd0, IMemReq}, {31'd0, req});
    chk({tag, ".addr"}, IMemAddr, addr);
    chk({tag, ".inst"}, Instruction, inst);
    chk({tag, ".p4"}, PCValP4, p4);
    chk({tag, ".vld"}, {31'd0, InstValid}, {31'd0, vld});
  endtask

  typedef struct {
    logic st, bc, ack;
    logic [31:0] npc;
    logic req;
    logic [31:0] addr, inst, p4;
    logic vld;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic bc, input logic ack, input logic [31:0] npc,
                              input logic req, input logic [31:0] addr, input logic [31:0] inst,
                              input logic [31:0] p4, input logic vld);
    vec_t v;
    v.st = st; v.bc = bc; v.ack = ack; v.npc = npc;
    v.req = req; v.addr = addr; v.inst = inst; v.p4 = p4; v.vld = vld;
    return v;
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  logic [31:0] exp_pc, exp_f, exp_b, hold_addr, pre_inst, pre_p4;
  logic busy, pre_stall, pre_vld;
  int rem, consumed;

  initial begin
    //         st bc ack npc           req addr          inst          p4            vld
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h00400000, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400004, 32'h00400000, 32'h00400004, 1));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400008, 32'h00400004, 32'h00400008, 1));
    tbl.push_back(mk(1, 0, 1, 0,            0, 32'h00400008, 32'h00400004, 32'h00400008, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 32'h00400008, 32'h00400004, 32'h00400008, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 32'h00400008, 32'h00400004, 32'h00400008, 1));
    tbl.push_back(mk(1, 0, 0, 0,            0, 32'h00400008, 32'h00400004, 32'h00400008, 1));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h0040000C, 32'h00400008, 32'h0040000C, 1));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h0040000C, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h0040000C, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400010, 32'h0040000C, 32'h00400010, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00400103, 1, 32'h00400010, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h00400010, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400100, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h00400100, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400104, 32'h00400100, 32'h00400104, 1));
    tbl.push_back(mk(1, 1, 1, 32'h00500000, 0, 32'h00400104, 32'h00400100, 32'h00400104, 1));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h00400108, 32'h00400104, 32'h00400108, 1));
    tbl.push_back(mk(0, 1, 1, 32'h00400200, 1, 32'h00400200, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400204, 32'h00400200, 32'h00400204, 1));
    tbl.push_back(mk(1, 0, 0, 0,            1, 32'h00400204, 32'h00400200, 32'h00400204, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00400300, 1, 32'h00400204, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 1, 1, 32'h00400400, 1, 32'h00400400, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400404, 32'h00400400, 32'h00400404, 1));
    tbl.push_back(mk(1, 0, 1, 0,            0, 32'h00400404, 32'h00400400, 32'h00400404, 1));
    tbl.push_back(mk(0, 1, 0, 32'h00400800, 1, 32'h00400800, 32'h0,        32'h0,        0));
    tbl.push_back(mk(0, 0, 1, 0,            1, 32'h00400804, 32'h00400800, 32'h00400804, 1));

    #1 Rst = 1;
    #2;
    chk_out("reset", 0, RPC, 0, 0, 0);
    chk("reset.fcnt", FetchCnt, 0);
    chk("reset.bcnt", BubbleCnt, 0);
    @(negedge Clk) Rst = 0;

    foreach (tbl[i]) begin
      Stall = tbl[i].st; BCond = tbl[i].bc; NewPCVal = tbl[i].npc;
      IMemAck = tbl[i].ack; IMemData = IMemAddr;
      @(posedge Clk); #1;
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].inst, tbl[i].p4, tbl[i].vld);
      @(negedge Clk);
    end

    Stall = 0; BCond = 1; NewPCVal = 32'hFFFF_FFFC; IMemAck = 1; IMemData = IMemAddr;
    @(posedge Clk); #1;
    chk_out("wrap_br", 1, 32'hFFFF_FFFC, 0, 0, 0);
    @(negedge Clk) BCond = 0; IMemAck = 1; IMemData = IMemAddr;
    @(posedge Clk); #1;
    chk_out("wrap", 1, 32'h0, 32'hFFFF_FFFC, 32'h0, 1);
    @(negedge Clk) IMemAck = 0;
    @(posedge Clk); #3;
    Rst = 1;
    #1;
    chk_out("async_rst", 0, RPC, 0, 0, 0);
    chk("async_rst.fcnt", FetchCnt, 0);
    chk("async_rst.bcnt", BubbleCnt, 0);
    @(negedge Clk) IMemAck = 1; IMemData = 32'hDEAD_BEEF;
    @(negedge Clk) Rst = 0;
    @(posedge Clk); #1;
    chk_out("idle_ack", 1, RPC, 0, 0, 0);
    @(negedge Clk);

    busy = 0; rem = 0; consumed = 0; exp_pc = RPC; exp_f = 0; exp_b = 0;
    for (int c = 0; c < 600; c++) begin
      Stall = ($urandom % 4) == 0;
      BCond = ($urandom % 6) == 0;
      NewPCVal = {RPC[31:12], 12'($urandom)};
      if (IMemReq) begin
        if (!busy) begin
          busy = 1;
          rem = $urandom_range(0, 3);
        end
        IMemAck = rem == 0;
        IMemData = mem(IMemAddr);
      end else begin
        IMemAck = 0;
        IMemData = $urandom;
      end
      hold_addr = IMemAddr;
      #1;
      pre_stall = Stall; pre_vld = InstValid; pre_inst = Instruction; pre_p4 = PCValP4;
      if (!InstValid) begin
        chk("bubble.inst", Instruction, 0);
        chk("bubble.p4", PCValP4, 0);
      end
      if (!Stall) begin
        if (InstValid) begin
          chk("stream.pc", PCValP4 - 32'd4, exp_pc);
          chk("stream.inst", Instruction, mem(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (BCond) exp_pc = NewPCVal & ~32'h3;
      end
      @(posedge Clk); #1;
      if (busy) begin
        if (IMemAck) busy = 0;
        else begin
          rem--;
          chk("req_held", {31'd0, IMemReq}, 1);
          chk("addr_held", IMemAddr, hold_addr);
        end
      end
      chk("addr_align", {30'd0, IMemAddr[1:0]}, 0);
      if (pre_stall) begin
        chk("stall_hold.vld", {31'd0, InstValid}, {31'd0, pre_vld});
        chk("stall_hold.inst", Instruction, pre_inst);
        chk("stall_hold.p4", PCValP4, pre_p4);
      end else if (InstValid) exp_f++;
      else exp_b++;
`ifdef IFETCH_PERF_EN
      chk("fetch_cnt", FetchCnt, exp_f);
      chk("bubble_cnt", BubbleCnt, exp_b);
`else
      chk("fetch_cnt", FetchCnt, 0);
      chk("bubble_cnt", BubbleCnt, 0);
`endif
      @(negedge Clk);
    end
    tests++;
    if (consumed < 60) begin
      fails++;
      $display("FAIL progress: got %0d instructions consumed, required at least 60", consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
